// File: rtl/ram8_arbiter.sv
// Two-requester round-robin arbiter in front of a RAM8-style memory.
// Requester A (CPU side) and requester B (peripheral side) each issue single-word
// reads or writes; the granted requester's load/address/in are steered onto the RAM
// and read data is captured into a shared registered output.
// Optional feature macro: ARB_LOCK_EN adds lock_a/lock_b grant holding with a
// forced release after 8 consecutive cycles of the same grant.
module ram8_arbiter #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              load_a,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [WIDTH-1:0]  in_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  input  logic              req_b,
  input  logic              load_b,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [WIDTH-1:0]  in_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [WIDTH-1:0]  out,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic [WIDTH-1:0]  ram_in,
  input  logic [WIDTH-1:0]  ram_out
`ifdef ARB_LOCK_EN
  ,
  input  logic              lock_a,
  input  logic              lock_b
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  // last_b set means B won most recently, so A wins the next tie
  logic   last_b;
  logic   last_b_next;
  logic   cand_a;
  logic   cand_b;
  logic   keep;

`ifdef ARB_LOCK_EN
  logic [2:0] lock_cnt;

  // Count cycles a locked grant has been extended; clears whenever the grant moves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_cnt <= 3'd0;
    end else if (keep) begin
      lock_cnt <= lock_cnt + 3'd1;
    end else begin
      lock_cnt <= 3'd0;
    end
  end
`endif

  // Next-state arbitration: mask the owner of the ending cycle, break ties by last winner
  always_comb begin
    state_next  = IDLE;
    last_b_next = last_b;
    keep        = 1'b0;
    cand_a      = req_a && (state != GNT_A);
    cand_b      = req_b && (state != GNT_B);
`ifdef ARB_LOCK_EN
    if ((state == GNT_A) && req_a && lock_a && (lock_cnt != 3'd7)) begin
      keep = 1'b1;
    end
    if ((state == GNT_B) && req_b && lock_b && (lock_cnt != 3'd7)) begin
      keep = 1'b1;
    end
`endif
    if (keep) begin
      state_next = state;
    end else if (cand_a && cand_b) begin
      state_next  = last_b ? GNT_A : GNT_B;
      last_b_next = !last_b;
    end else if (cand_a) begin
      state_next  = GNT_A;
      last_b_next = 1'b0;
    end else if (cand_b) begin
      state_next  = GNT_B;
      last_b_next = 1'b1;
    end
  end

  // State and round-robin history registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last_b <= 1'b1;
    end else begin
      state  <= state_next;
      last_b <= last_b_next;
    end
  end

  // Capture read data and pulse rvalid at the edge that ends a read grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out      <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= (state == GNT_A) && !load_a;
      rvalid_b <= (state == GNT_B) && !load_b;
      if (((state == GNT_A) && !load_a) || ((state == GNT_B) && !load_b)) begin
        out <= ram_out;
      end
    end
  end

  assign gnt_a = (state == GNT_A);
  assign gnt_b = (state == GNT_B);

  // Steer the owner's request onto the RAM; everything is zero while idle
  always_comb begin
    ram_load    = 1'b0;
    ram_address = '0;
    ram_in      = '0;
    if (state == GNT_A) begin
      ram_load    = load_a;
      ram_address = address_a;
      ram_in      = in_a;
    end else if (state == GNT_B) begin
      ram_load    = load_b;
      ram_address = address_b;
      ram_in      = in_b;
    end
  end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Self-checking bench for ram8_arbiter: directed scenarios followed by random
// transactions, all compared against a transaction-level reference model.
// Builds with or without ARB_LOCK_EN.
module tb_ram8_arbiter;

  localparam int NONE = 0;
  localparam int OWN_A = 1;
  localparam int OWN_B = 2;

  logic        clk;
  logic        reset;
  logic        req_a, load_a, gnt_a, rvalid_a;
  logic [2:0]  address_a;
  logic [15:0] in_a;
  logic        req_b, load_b, gnt_b, rvalid_b;
  logic [2:0]  address_b;
  logic [15:0] in_b;
  logic [15:0] out_data;
  logic        ram_load;
  logic [2:0]  ram_address;
  logic [15:0] ram_in;
  logic [15:0] ram_out;
`ifdef ARB_LOCK_EN
  logic        lock_a, lock_b;
`endif

  // Memory behind the arbiter
  logic [15:0] mem [8];
  // Reference model state
  logic [15:0] ref_mem [8];
  int          exp_owner;
  int          exp_last;
  int          run_len;
  logic        exp_rv_a, exp_rv_b;
  logic [15:0] exp_out;

  int checks;
  int errors;

  ram8_arbiter #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .load_a(load_a), .address_a(address_a), .in_a(in_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .load_b(load_b), .address_b(address_b), .in_b(in_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b),
    .out(out_data),
    .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in),
    .ram_out(ram_out)
`ifdef ARB_LOCK_EN
    , .lock_a(lock_a), .lock_b(lock_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM8: combinational read, write on the rising edge
  assign ram_out = mem[ram_address];
  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
  end

  task automatic expect_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    exp_owner = NONE;
    exp_last  = OWN_B;
    run_len   = 0;
    exp_rv_a  = 1'b0;
    exp_rv_b  = 1'b0;
    exp_out   = 16'h0000;
  endtask

  // One rising edge of the reference: finish the ending transaction, then pick the next owner
  task automatic model_edge();
    int  prev;
    bit  ca, cb, hold;
    if (reset) begin
      model_reset();
      return;
    end
    prev     = exp_owner;
    exp_rv_a = 1'b0;
    exp_rv_b = 1'b0;
    if (prev == OWN_A) begin
      if (load_a) ref_mem[address_a] = in_a;
      else begin exp_rv_a = 1'b1; exp_out = ref_mem[address_a]; end
    end
    if (prev == OWN_B) begin
      if (load_b) ref_mem[address_b] = in_b;
      else begin exp_rv_b = 1'b1; exp_out = ref_mem[address_b]; end
    end
    hold = 1'b0;
`ifdef ARB_LOCK_EN
    if (prev == OWN_A && req_a && lock_a && run_len < 8) hold = 1'b1;
    if (prev == OWN_B && req_b && lock_b && run_len < 8) hold = 1'b1;
`endif
    if (hold) begin
      run_len++;
    end else begin
      ca = req_a && (prev != OWN_A);
      cb = req_b && (prev != OWN_B);
      if (ca && cb)  exp_owner = (exp_last == OWN_A) ? OWN_B : OWN_A;
      else if (ca)   exp_owner = OWN_A;
      else if (cb)   exp_owner = OWN_B;
      else           exp_owner = NONE;
      if (exp_owner != NONE) exp_last = exp_owner;
      run_len = (exp_owner == NONE) ? 0 : 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_output(input string tag);
    logic        e_load;
    logic [2:0]  e_addr;
    logic [15:0] e_in;
    @(negedge clk);
    e_load = 1'b0; e_addr = 3'd0; e_in = 16'h0000;
    if (exp_owner == OWN_A) begin e_load = load_a; e_addr = address_a; e_in = in_a; end
    if (exp_owner == OWN_B) begin e_load = load_b; e_addr = address_b; e_in = in_b; end
    expect_eq({tag, ".gnt_a"}, 32'(gnt_a), 32'(exp_owner == OWN_A));
    expect_eq({tag, ".gnt_b"}, 32'(gnt_b), 32'(exp_owner == OWN_B));
    expect_eq({tag, ".rvalid_a"}, 32'(rvalid_a), 32'(exp_rv_a));
    expect_eq({tag, ".rvalid_b"}, 32'(rvalid_b), 32'(exp_rv_b));
    expect_eq({tag, ".out"}, 32'(out_data), 32'(exp_out));
    expect_eq({tag, ".ram_load"}, 32'(ram_load), 32'(e_load));
    expect_eq({tag, ".ram_address"}, 32'(ram_address), 32'(e_addr));
    expect_eq({tag, ".ram_in"}, 32'(ram_in), 32'(e_in));
  endtask

  task automatic apply_stimulus_random(input int cycles);
    int prev;
    for (int c = 0; c < cycles; c++) begin
      prev = exp_owner;
      tick();
      if (exp_owner != OWN_A && (prev == OWN_A || !req_a)) begin
        req_a = ($urandom_range(0, 2) != 0);
        if (req_a) begin
          load_a = 1'($urandom_range(0, 1));
          address_a = 3'($urandom_range(0, 7));
          in_a = 16'($urandom);
        end
      end
      if (exp_owner != OWN_B && (prev == OWN_B || !req_b)) begin
        req_b = ($urandom_range(0, 2) != 0);
        if (req_b) begin
          load_b = 1'($urandom_range(0, 1));
          address_b = 3'($urandom_range(0, 7));
          in_b = 16'($urandom);
        end
      end
`ifdef ARB_LOCK_EN
      lock_a = ($urandom_range(0, 3) == 0);
      lock_b = ($urandom_range(0, 3) == 0);
`endif
      check_output("rand");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    req_a = 0; load_a = 0; address_a = 0; in_a = 0;
    req_b = 0; load_b = 0; address_b = 0; in_b = 0;
`ifdef ARB_LOCK_EN
    lock_a = 0; lock_b = 0;
`endif
    for (int i = 0; i < 8; i++) begin
      mem[i] = {4{4'(i)}};
      ref_mem[i] = {4{4'(i)}};
    end
    mem[2] = 16'hBEEF;
    ref_mem[2] = 16'hBEEF;
    model_reset();

    // Reset state
    tick(); tick();
    check_output("reset");
    expect_eq("reset.out_zero", 32'(out_data), 32'h0);
    tick(); reset = 1'b0;
    check_output("idle");

    // Lone A read of address 2
    tick(); req_a = 1; load_a = 0; address_a = 3'd2;
    check_output("rd_req");
    tick(); req_a = 0;
    check_output("rd_gnt");
    expect_eq("rd_gnt.gnt_a", 32'(gnt_a), 32'h1);
    tick();
    check_output("rd_data");
    expect_eq("rd_data.rvalid_a", 32'(rvalid_a), 32'h1);
    expect_eq("rd_data.out", 32'(out_data), 32'hBEEF);
    expect_eq("rd_data.gnt_b", 32'(gnt_b), 32'h0);

    // Reset cuts a GNT_A write to address 5
    tick(); req_a = 1; load_a = 1; address_a = 3'd5; in_a = 16'h1234;
    tick();
    check_output("cut_gnt");
    expect_eq("cut_gnt.ram_load", 32'(ram_load), 32'h1);
    #1 reset = 1'b1;
    model_reset();
    req_a = 0; load_a = 0;
    #1;
    expect_eq("cut.gnt_a", 32'(gnt_a), 32'h0);
    expect_eq("cut.ram_load", 32'(ram_load), 32'h0);
    tick(); tick(); reset = 1'b0;
    check_output("cut_after");
    expect_eq("cut.mem5", 32'(mem[5]), 32'h5555);

    // Simultaneous A and B writes alternate A,B,A,B
    tick();
    req_a = 1; load_a = 1; address_a = 3'd1; in_a = 16'hAAAA;
    req_b = 1; load_b = 1; address_b = 3'd4; in_b = 16'hBBBB;
    check_output("ab_req");
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) begin address_a = 3'd3; in_a = 16'hA5A5; end
      if (i == 2) begin address_b = 3'd6; in_b = 16'hB5B5; end
      if (i == 3) req_a = 0;
      check_output("ab_seq");
      expect_eq("ab_seq.gnt_a", 32'(gnt_a), 32'(i % 2 == 0));
      expect_eq("ab_seq.gnt_b", 32'(gnt_b), 32'(i % 2 == 1));
    end
    tick(); req_b = 0;
    check_output("ab_done");
    expect_eq("ab.mem1", 32'(mem[1]), 32'hAAAA);
    expect_eq("ab.mem4", 32'(mem[4]), 32'hBBBB);
    expect_eq("ab.mem3", 32'(mem[3]), 32'hA5A5);
    expect_eq("ab.mem6", 32'(mem[6]), 32'hB5B5);

    // A held continuously with no B: grant every other cycle
    tick(); req_a = 1; load_a = 0; address_a = 3'd2;
    check_output("hold_req");
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output("hold");
      expect_eq("hold.gnt_a", 32'(gnt_a), 32'(i % 2 == 0));
    end
    req_a = 0;
    tick(); check_output("hold_end");

    // Both held, A locked when the feature exists
    reset = 1'b1; model_reset();
    tick(); reset = 1'b0;
    req_a = 1; load_a = 0; address_a = 3'd0;
    req_b = 1; load_b = 0; address_b = 3'd7;
`ifdef ARB_LOCK_EN
    lock_a = 1;
`endif
    for (int i = 0; i < 9; i++) begin
      tick();
      check_output("both");
`ifdef ARB_LOCK_EN
      expect_eq("lock.gnt_a", 32'(gnt_a), 32'(i < 8));
      expect_eq("lock.gnt_b", 32'(gnt_b), 32'(i == 8));
`else
      expect_eq("alt.gnt_a", 32'(gnt_a), 32'(i % 2 == 0));
      expect_eq("alt.gnt_b", 32'(gnt_b), 32'(i % 2 == 1));
`endif
    end
    req_a = 0; req_b = 0;
`ifdef ARB_LOCK_EN
    lock_a = 0;
`endif
    tick(); check_output("both_drain1");
    tick(); check_output("both_drain2");

    // B writes 00FF to address 7, then A reads it back
    tick(); req_b = 1; load_b = 1; address_b = 3'd7; in_b = 16'h00FF;
    tick(); req_b = 0;
    check_output("bw_gnt");
    tick(); req_a = 1; load_a = 0; address_a = 3'd7;
    check_output("ar_req");
    tick(); req_a = 0;
    check_output("ar_gnt");
    tick();
    check_output("ar_data");
    expect_eq("ar_data.rvalid_a", 32'(rvalid_a), 32'h1);
    expect_eq("ar_data.out", 32'(out_data), 32'h00FF);

    // Random traffic against the model
    apply_stimulus_random(400);
    req_a = 0; req_b = 0;
`ifdef ARB_LOCK_EN
    lock_a = 0; lock_b = 0;
`endif
    tick(); tick(); tick();
    check_output("final");
    for (int i = 0; i < 8; i++) begin
      expect_eq("final.mem", 32'(mem[i]), 32'(ref_mem[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
